// File: rtl/runner_physics_core.sv
// Per-frame runner player physics: lane moves, RUN/AIR/DUCK/DEAD FSM, obstacle snapshot, score/progress.
// Optional macro DOUBLE_JUMP_EN adds one extra mid-air jump per airborne phase.
module runner_physics_core #(
    parameter int NUM_LANES         = 3,
    parameter int HEIGHT_W          = 16,
    parameter int HALF_BLOCK_LENGTH = 64,
    parameter int SPEED             = 4,
    parameter int GRAVITY           = 2,
    parameter int JUMP_VELOCITY     = 20,
    parameter int DUCK_LIMIT        = 15,
    parameter int GROUND            = -128,
    parameter int TRAIN_HEIGHT      = 64,
    parameter int MARGIN            = 10,
    localparam int LANE_W           = $clog2(NUM_LANES),
    localparam int PROG_W           = $clog2(HALF_BLOCK_LENGTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_frame,
    input  logic                       obstacle_valid,
    input  logic [2:0]                 obstacle_type,
    input  logic [LANE_W-1:0]          obstacle_lane,
    input  logic                       firstrow,
    input  logic                       duck,
    input  logic                       jump,
    input  logic                       left,
    input  logic                       right,
    output logic [1:0]                 state,
    output logic                       game_over,
    output logic [LANE_W-1:0]          player_lane,
    output logic signed [HEIGHT_W-1:0] player_height,
    output logic [15:0]                player_score,
    output logic [PROG_W-1:0]          half_block_progress
);
    localparam int TIMER_W = $clog2(DUCK_LIMIT + 1);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_AIR  = 2'd1;
    localparam logic [1:0] S_DUCK = 2'd2;
    localparam logic [1:0] S_DEAD = 2'd3;

    localparam logic signed [HEIGHT_W:0] L_GROUND    = (HEIGHT_W+1)'(GROUND);
    localparam logic signed [HEIGHT_W:0] L_ROOF      = (HEIGHT_W+1)'(GROUND + TRAIN_HEIGHT);
    localparam logic signed [HEIGHT_W:0] L_MARGIN    = (HEIGHT_W+1)'(MARGIN);
    localparam logic signed [HEIGHT_W:0] L_LOW_CLEAR = (HEIGHT_W+1)'(GROUND + HALF_BLOCK_LENGTH/2);
    localparam logic signed [7:0]        L_JUMP_V    = 8'(JUMP_VELOCITY);
    localparam logic signed [7:0]        L_GRAV      = 8'(GRAVITY);

    logic [1:0]                 r_state, w_state_n;
    logic [LANE_W-1:0]          r_lane, w_lane_n;
    logic signed [HEIGHT_W-1:0] r_height, w_height_n;
    logic signed [7:0]          r_vel, w_vel_n;
    logic [15:0]                r_score, w_score_n;
    logic [PROG_W-1:0]          r_prog, w_prog_n;
    logic [TIMER_W-1:0]         r_timer, w_timer_n;
    logic [3:0]                 r_snap;
    logic                       r_ff_used, w_ff_n;

    logic                       w_hit, w_crash, w_ff_fire, w_dj_fire;
    logic [3:0]                 w_obs_bits;
    logic signed [HEIGHT_W:0]   w_h_ext, w_ground, w_floor_min, w_h_air, w_v_ext;
    logic signed [7:0]          w_v_air;
    logic [16:0]                w_score_sum;
    logic [PROG_W:0]            w_prog_sum;

`ifdef DOUBLE_JUMP_EN
    logic                       r_dj_used, w_dj_n;
    assign w_dj_fire = jump && !duck && !r_dj_used;
`else
    assign w_dj_fire = 1'b0;
`endif

    // Snapshot bits: [0] low, [1] high, [2] mid, [3] train.
    always_comb begin
        w_obs_bits = '0;
        case (obstacle_type)
            3'd1:    w_obs_bits[0] = 1'b1;
            3'd2:    w_obs_bits[1] = 1'b1;
            3'd3:    w_obs_bits[2] = 1'b1;
            3'd4:    w_obs_bits[3] = 1'b1;
            default: w_obs_bits = '0;
        endcase
    end

    assign w_hit       = obstacle_valid && firstrow && (obstacle_lane == r_lane);
    assign w_h_ext     = {r_height[HEIGHT_W-1], r_height};
    assign w_ground    = r_snap[3] ? L_ROOF : L_GROUND;
    assign w_floor_min = w_ground - L_MARGIN;
    assign w_ff_fire   = duck && !r_ff_used;
    assign w_v_air     = r_vel - L_GRAV - (w_ff_fire ? L_JUMP_V : 8'sd0);
    assign w_v_ext     = {{(HEIGHT_W-7){w_v_air[7]}}, w_v_air};
    assign w_h_air     = w_h_ext + w_v_ext;
    assign w_score_sum = {1'b0, r_score} + 17'(SPEED);
    assign w_prog_sum  = {1'b0, r_prog} + (PROG_W+1)'(SPEED);

    // Barriers only bite when the player is centred on the block; the train bites whenever too low.
    assign w_crash = ((r_prog == PROG_W'(HALF_BLOCK_LENGTH/2)) &&
                      ((r_snap[0] && !(w_h_ext > L_LOW_CLEAR)) ||
                       (r_snap[1] && (r_state != S_DUCK)) ||
                       (r_snap[2] && !(w_h_ext > L_LOW_CLEAR) && (r_state != S_DUCK)))) ||
                     (r_snap[3] && (w_h_ext < w_floor_min));

    always_comb begin
        w_state_n  = r_state;
        w_lane_n   = r_lane;
        w_height_n = r_height;
        w_vel_n    = r_vel;
        w_score_n  = r_score;
        w_prog_n   = r_prog;
        w_timer_n  = r_timer;
        w_ff_n     = r_ff_used;
`ifdef DOUBLE_JUMP_EN
        w_dj_n     = r_dj_used;
`endif
        if (w_crash) begin
            w_state_n = S_DEAD;
        end else begin
            w_score_n = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            w_prog_n  = (w_prog_sum >= (PROG_W+1)'(HALF_BLOCK_LENGTH)) ? '0 : w_prog_sum[PROG_W-1:0];
            if (left && !right && (r_lane != '0))
                w_lane_n = r_lane - LANE_W'(1);
            else if (right && !left && (r_lane != LANE_W'(NUM_LANES-1)))
                w_lane_n = r_lane + LANE_W'(1);
            case (r_state)
                S_RUN: begin
                    if (duck) begin
                        w_state_n = S_DUCK;
                        w_timer_n = TIMER_W'(DUCK_LIMIT);
                    end else if (jump) begin
                        w_state_n  = S_AIR;
                        w_vel_n    = L_JUMP_V;
                        w_height_n = r_height + HEIGHT_W'(JUMP_VELOCITY);
                    end else if (w_h_ext > w_ground) begin
                        w_state_n = S_AIR;
                        w_vel_n   = '0;
                    end else if ((w_h_ext >= w_floor_min) && (w_h_ext < w_ground)) begin
                        w_height_n = w_ground[HEIGHT_W-1:0];
                    end
                end
                S_AIR: begin
                    if (w_dj_fire) begin
                        w_vel_n = L_JUMP_V;
`ifdef DOUBLE_JUMP_EN
                        w_dj_n  = 1'b1;
`endif
                    end else if (w_h_air <= w_ground) begin
                        if (w_h_air >= w_floor_min) begin
                            w_state_n  = S_RUN;
                            w_height_n = w_ground[HEIGHT_W-1:0];
                            w_vel_n    = '0;
                            w_ff_n     = 1'b0;
`ifdef DOUBLE_JUMP_EN
                            w_dj_n     = 1'b0;
`endif
                        end else begin
                            w_state_n = S_DEAD;
                        end
                    end else begin
                        w_height_n = w_h_air[HEIGHT_W-1:0];
                        w_vel_n    = w_v_air;
                        if (w_ff_fire) w_ff_n = 1'b1;
                    end
                end
                S_DUCK: begin
                    if (r_timer == TIMER_W'(1)) begin
                        if (duck) begin
                            w_timer_n = TIMER_W'(DUCK_LIMIT);
                        end else begin
                            w_state_n = S_RUN;
                            w_timer_n = '0;
                        end
                    end else begin
                        w_timer_n = r_timer - TIMER_W'(1);
                    end
                end
                default: w_state_n = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_RUN;
            r_lane    <= LANE_W'(NUM_LANES/2);
            r_height  <= L_GROUND[HEIGHT_W-1:0];
            r_vel     <= '0;
            r_score   <= '0;
            r_prog    <= '0;
            r_timer   <= '0;
            r_snap    <= '0;
            r_ff_used <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            r_dj_used <= 1'b0;
`endif
        end else begin
            // A same-cycle obstacle seeds the fresh snapshot rather than the frame being processed.
            if (new_frame)
                r_snap <= w_hit ? w_obs_bits : '0;
            else if (w_hit)
                r_snap <= r_snap | w_obs_bits;
            if (new_frame && (r_state != S_DEAD)) begin
                r_state   <= w_state_n;
                r_lane    <= w_lane_n;
                r_height  <= w_height_n;
                r_vel     <= w_vel_n;
                r_score   <= w_score_n;
                r_prog    <= w_prog_n;
                r_timer   <= w_timer_n;
                r_ff_used <= w_ff_n;
`ifdef DOUBLE_JUMP_EN
                r_dj_used <= w_dj_n;
`endif
            end
        end
    end

    assign state               = r_state;
    assign game_over           = (r_state == S_DEAD);
    assign player_lane         = r_lane;
    assign player_height       = r_height;
    assign player_score        = r_score;
    assign half_block_progress = r_prog;
endmodule
